// File: rtl/fpu_op_sequencer.sv
// Operand sequencer and result collector for an FPU add/sub core: replays a loaded
// table of (X, Y, op, r_mode) entries through the beg/ready/rst handshake and logs results.
module fpu_op_sequencer #(
    parameter int W   = 64,
    parameter int AW  = 10,
    parameter int TMO = 255,
    parameter int LW  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_ld_we,
    input  logic [AW-1:0]     i_ld_addr,
    input  logic [W-1:0]      i_ld_x,
    input  logic [W-1:0]      i_ld_y,
    input  logic [2:0]        i_ld_op,
    input  logic              i_start,
    input  logic [AW:0]       i_num_ops,
    output logic              o_busy,
    output logic              o_done,
    output logic [W-1:0]      o_dut_x,
    output logic [W-1:0]      o_dut_y,
    output logic              o_dut_add_subt,
    output logic [1:0]        o_dut_r_mode,
    output logic              o_dut_beg,
    output logic              o_dut_rst,
    input  logic              i_dut_ready,
    input  logic [W-1:0]      i_dut_result,
    input  logic              i_dut_ovf,
    input  logic              i_dut_unf,
    input  logic [AW-1:0]     i_rd_addr,
    output logic [W-1:0]      o_rd_result,
    output logic [2+LW:0]     o_rd_status,
    output logic              o_tmo_err,
    output logic [LW-1:0]     o_lat_max
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_BEG,
        S_WAIT,
        S_CAPT,
        S_FIN
    } state_t;

    localparam int              DEPTH   = 1 << AW;
    localparam int              SW      = 3 + LW;
    localparam int              TW      = 2 * W + 3;
    localparam logic [AW:0]     MAX_OPS = (AW + 1)'(DEPTH);
    localparam logic [LW-1:0]   TMO_L   = LW'(TMO);

    state_t          r_state;
    state_t          w_next;

    logic [TW-1:0]   r_tab  [DEPTH];
    logic [W-1:0]    r_res  [DEPTH];
    logic [SW-1:0]   r_stat [DEPTH];

    logic [AW:0]     r_idx;
    logic [AW:0]     r_num;
    logic [LW-1:0]   r_lat;
    logic [W-1:0]    r_cap_res;
    logic [SW-1:0]   r_cap_stat;
    logic [W-1:0]    r_dut_x;
    logic [W-1:0]    r_dut_y;
    logic [2:0]      r_dut_op;
    logic            r_tmo_err;
    logic [LW-1:0]   r_lat_max;
    logic            r_done;
    logic [W-1:0]    r_rd_result;
    logic [SW-1:0]   r_rd_status;

    logic [AW:0]     w_idx_inc;
    logic [AW:0]     w_num_clamped;
    logic [LW-1:0]   w_lat_inc;
    logic            w_timeout;
    logic [TW-1:0]   w_entry;

    assign w_idx_inc     = r_idx + 1'b1;
    assign w_num_clamped = (i_num_ops > MAX_OPS) ? MAX_OPS : i_num_ops;
    assign w_lat_inc     = r_lat + 1'b1;
    assign w_timeout     = (w_lat_inc == TMO_L);
    assign w_entry       = r_tab[r_idx[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // dut_ready is only looked at in WAIT, so an early ready during BEG is ignored
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next = (w_num_clamped == '0) ? S_FIN : S_SETUP;
                end
            end
            S_SETUP: w_next = S_BEG;
            S_BEG:   w_next = S_WAIT;
            S_WAIT: begin
                if (i_dut_ready || w_timeout) begin
                    w_next = S_CAPT;
                end
            end
            S_CAPT:  w_next = (w_idx_inc == r_num) ? S_FIN : S_SETUP;
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx      <= '0;
            r_num      <= '0;
            r_lat      <= '0;
            r_cap_res  <= '0;
            r_cap_stat <= '0;
            r_dut_x    <= '0;
            r_dut_y    <= '0;
            r_dut_op   <= '0;
            r_tmo_err  <= 1'b0;
            r_lat_max  <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= (r_state == S_FIN);
            case (r_state)
                S_IDLE: begin
                    if (i_start && (w_num_clamped != '0)) begin
                        r_idx     <= '0;
                        r_num     <= w_num_clamped;
                        r_tmo_err <= 1'b0;
                        r_lat_max <= '0;
                    end
                end
                S_SETUP: begin
                    r_dut_op <= w_entry[TW-1 -: 3];
                    r_dut_x  <= w_entry[2*W-1 -: W];
                    r_dut_y  <= w_entry[W-1:0];
                end
                S_BEG: begin
                    r_lat <= '0;
                end
                S_WAIT: begin
                    r_lat <= w_lat_inc;
                    if (i_dut_ready) begin
                        r_cap_res  <= i_dut_result;
                        r_cap_stat <= {1'b0, i_dut_ovf, i_dut_unf, w_lat_inc};
                    end else if (w_timeout) begin
                        r_cap_res  <= '1;
                        r_cap_stat <= {3'b100, TMO_L};
                        r_tmo_err  <= 1'b1;
                    end
                end
                S_CAPT: begin
                    if (r_cap_stat[LW-1:0] > r_lat_max) begin
                        r_lat_max <= r_cap_stat[LW-1:0];
                    end
                    r_idx <= w_idx_inc;
                end
                default: ;
            endcase
        end
    end

    // Table and result storage are deliberately not reset so a run can be re-read after rst
    always_ff @(posedge clk) begin
        if (i_ld_we && (r_state == S_IDLE)) begin
            r_tab[i_ld_addr] <= {i_ld_op, i_ld_x, i_ld_y};
        end
        if (r_state == S_CAPT) begin
            r_res[r_idx[AW-1:0]]  <= r_cap_res;
            r_stat[r_idx[AW-1:0]] <= r_cap_stat;
        end
        r_rd_result <= r_res[i_rd_addr];
        r_rd_status <= r_stat[i_rd_addr];
    end

    assign o_busy         = (r_state != S_IDLE);
    assign o_done         = r_done;
    assign o_dut_x        = r_dut_x;
    assign o_dut_y        = r_dut_y;
    assign o_dut_add_subt = r_dut_op[2];
    assign o_dut_r_mode   = r_dut_op[1:0];
    assign o_dut_beg      = (r_state == S_BEG);
    assign o_dut_rst      = (r_state == S_CAPT);
    assign o_rd_result    = r_rd_result;
    assign o_rd_status    = r_rd_status;
    assign o_tmo_err      = r_tmo_err;
    assign o_lat_max      = r_lat_max;

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Directed bench for fpu_op_sequencer: a 64-bit instance against a programmable-latency
// FPU model, plus a 32-bit instance against a fixed-latency model.
module tb_fpu_op_sequencer;

    localparam int AW = 4;
    localparam int LW = 8;
    localparam int SW = 3 + LW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic            ldWe;
    logic [AW-1:0]   ldAddr;
    logic [63:0]     ldX, ldY;
    logic [2:0]      ldOp;
    logic            start;
    logic [AW:0]     numOps;
    logic            busy, done;
    logic [63:0]     dX, dY;
    logic            dAddSubt;
    logic [1:0]      dRMode;
    logic            dBeg, dRst, dReady;
    logic [63:0]     dResult;
    logic            dOvf, dUnf;
    logic [AW-1:0]   rdAddr;
    logic [63:0]     rdResult;
    logic [SW-1:0]   rdStatus;
    logic            tmoErr;
    logic [LW-1:0]   latMax;

    logic            bLdWe;
    logic [AW-1:0]   bLdAddr;
    logic [31:0]     bLdX, bLdY;
    logic [2:0]      bLdOp;
    logic            bStart;
    logic [AW:0]     bNumOps;
    logic            bBusy, bDone;
    logic [31:0]     bX, bY;
    logic            bAddSubt;
    logic [1:0]      bRMode;
    logic            bBeg, bRst, bReady;
    logic [31:0]     bResult;
    logic            bOvf, bUnf;
    logic [AW-1:0]   bRdAddr;
    logic [31:0]     bRdResult;
    logic [SW-1:0]   bRdStatus;
    logic            bTmoErr;
    logic [LW-1:0]   bLatMax;

    int total = 0;
    int bad   = 0;

    fpu_op_sequencer #(.W(64), .AW(AW), .TMO(20), .LW(LW)) u64 (
        .clk(clk), .rst(rst),
        .i_ld_we(ldWe), .i_ld_addr(ldAddr), .i_ld_x(ldX), .i_ld_y(ldY), .i_ld_op(ldOp),
        .i_start(start), .i_num_ops(numOps),
        .o_busy(busy), .o_done(done),
        .o_dut_x(dX), .o_dut_y(dY), .o_dut_add_subt(dAddSubt), .o_dut_r_mode(dRMode),
        .o_dut_beg(dBeg), .o_dut_rst(dRst),
        .i_dut_ready(dReady), .i_dut_result(dResult), .i_dut_ovf(dOvf), .i_dut_unf(dUnf),
        .i_rd_addr(rdAddr), .o_rd_result(rdResult), .o_rd_status(rdStatus),
        .o_tmo_err(tmoErr), .o_lat_max(latMax)
    );

    fpu_op_sequencer #(.W(32), .AW(AW), .TMO(20), .LW(LW)) u32 (
        .clk(clk), .rst(rst),
        .i_ld_we(bLdWe), .i_ld_addr(bLdAddr), .i_ld_x(bLdX), .i_ld_y(bLdY), .i_ld_op(bLdOp),
        .i_start(bStart), .i_num_ops(bNumOps),
        .o_busy(bBusy), .o_done(bDone),
        .o_dut_x(bX), .o_dut_y(bY), .o_dut_add_subt(bAddSubt), .o_dut_r_mode(bRMode),
        .o_dut_beg(bBeg), .o_dut_rst(bRst),
        .i_dut_ready(bReady), .i_dut_result(bResult), .i_dut_ovf(bOvf), .i_dut_unf(bUnf),
        .i_rd_addr(bRdAddr), .o_rd_result(bRdResult), .o_rd_status(bRdStatus),
        .o_tmo_err(bTmoErr), .o_lat_max(bLatMax)
    );

    // 64-bit FPU model: latency per entry comes from latArr (0 = never ready)
    int nbeg  = 0;
    int nrst  = 0;
    int ndone = 0;
    int base  = 0;
    int latArr [4];
    int mCnt, mCur;
    logic mAct;

    always @(posedge clk) begin
        if (rst) begin
            mAct <= 1'b0;
            mCnt <= 0;
            mCur <= 0;
        end else if (dBeg) begin
            mAct <= 1'b1;
            mCnt <= 1;
            mCur <= latArr[(nbeg - base) & 3];
        end else if (dRst) begin
            mAct <= 1'b0;
        end else if (mAct) begin
            mCnt <= mCnt + 1;
        end
    end

    always @(posedge clk) begin
        if (dBeg)  nbeg  <= nbeg + 1;
        if (dRst)  nrst  <= nrst + 1;
        if (done)  ndone <= ndone + 1;
    end

    assign dReady = mAct && (mCur != 0) && (mCnt == mCur);

    // 32-bit FPU model: ready three cycles after each begin pulse
    int bCnt;
    always @(posedge clk) begin
        if (rst)              bCnt <= 0;
        else if (bBeg)        bCnt <= 1;
        else if (bRst)        bCnt <= 0;
        else if (bCnt != 0)   bCnt <= bCnt + 1;
    end
    assign bReady = (bCnt == 3);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load64(input logic [AW-1:0] a, input logic [63:0] x, input logic [63:0] y,
                          input logic [2:0] op);
        @(negedge clk);
        ldWe = 1'b1; ldAddr = a; ldX = x; ldY = y; ldOp = op;
        @(negedge clk);
        ldWe = 1'b0;
    endtask

    task automatic startRun64(input int n);
        @(negedge clk);
        base   = nbeg;
        start  = 1'b1;
        numOps = (AW + 1)'(n);
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic waitDone64(input int budget, input string tag);
        bit got;
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        chk(tag, 64'(got), 64'd1);
        @(negedge clk);
    endtask

    task automatic read64(input logic [AW-1:0] a, output logic [63:0] r, output logic [SW-1:0] s);
        @(negedge clk);
        rdAddr = a;
        @(negedge clk);
        r = rdResult;
        s = rdStatus;
    endtask

    task automatic run32(input string tag);
        bit got;
        @(negedge clk);
        bStart = 1'b1; bNumOps = 5'd1;
        @(negedge clk);
        bStart = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bDone) begin
                got = 1'b1;
                break;
            end
        end
        chk(tag, 64'(got), 64'd1);
        @(negedge clk);
        bRdAddr = '0;
        @(negedge clk);
    endtask

    logic [63:0]   r;
    logic [SW-1:0] s;
    int d0, b0, r0;

    initial begin
        rst = 1'b1;
        ldWe = 0; ldAddr = 0; ldX = 0; ldY = 0; ldOp = 0; start = 0; numOps = 0;
        dResult = 0; dOvf = 0; dUnf = 0; rdAddr = 0;
        bLdWe = 0; bLdAddr = 0; bLdX = 0; bLdY = 0; bLdOp = 0; bStart = 0; bNumOps = 0;
        bResult = 0; bOvf = 0; bUnf = 0; bRdAddr = 0;
        latArr = '{0, 0, 0, 0};
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_beg", 64'(dBeg), 64'd0);
        chk("rst_dutrst", 64'(dRst), 64'd0);
        chk("rst_x", dX, 64'd0);
        chk("rst_tmo", 64'(tmoErr), 64'd0);
        chk("rst_latmax", 64'(latMax), 64'd0);
        rst = 1'b0;

        // single add, 1.0 + 1.0, model latency 5
        load64(0, 64'h3FF0000000000000, 64'h3FF0000000000000, 3'b000);
        latArr[0] = 5;
        dResult = 64'h4000000000000000;
        d0 = ndone; b0 = nbeg;
        startRun64(1);
        waitDone64(40, "t1_done_wait");
        chk("t1_done_pulses", 64'(ndone - d0), 64'd1);
        chk("t1_beg_pulses", 64'(nbeg - b0), 64'd1);
        read64(0, r, s);
        chk("t1_result", r, 64'h4000000000000000);
        chk("t1_status", 64'(s), 64'h005);
        chk("t1_latmax", 64'(latMax), 64'd5);
        chk("t1_addsubt", 64'(dAddSubt), 64'd0);

        // four subtracts, 2.0 - 1.0
        for (int i = 0; i < 4; i++) begin
            load64(AW'(i), 64'h4000000000000000, 64'h3FF0000000000000, 3'b100);
        end
        latArr = '{3, 3, 3, 3};
        dResult = 64'h3FF0000000000000;
        d0 = ndone; b0 = nbeg; r0 = nrst;
        startRun64(4);
        waitDone64(80, "t2_done_wait");
        chk("t2_beg_pulses", 64'(nbeg - b0), 64'd4);
        chk("t2_rst_pulses", 64'(nrst - r0), 64'd4);
        chk("t2_done_pulses", 64'(ndone - d0), 64'd1);
        chk("t2_addsubt", 64'(dAddSubt), 64'd1);
        for (int i = 0; i < 4; i++) begin
            read64(AW'(i), r, s);
            chk("t2_result", r, 64'h3FF0000000000000);
            chk("t2_status", 64'(s), 64'h003);
        end

        // timeout on entry 0, entry 1 still runs
        latArr = '{0, 4, 0, 0};
        b0 = nbeg;
        startRun64(2);
        waitDone64(80, "t3_done_wait");
        chk("t3_beg_pulses", 64'(nbeg - b0), 64'd2);
        read64(0, r, s);
        chk("t3_tmo_result", r, 64'hFFFFFFFFFFFFFFFF);
        chk("t3_tmo_status", 64'(s), 64'h414);
        read64(1, r, s);
        chk("t3_next_result", r, 64'h3FF0000000000000);
        chk("t3_next_status", 64'(s), 64'h004);
        chk("t3_tmo_err", 64'(tmoErr), 64'd1);
        chk("t3_latmax", 64'(latMax), 64'd20);

        // varying latency with start/ld_we intrusions while busy
        latArr = '{2, 9, 4, 0};
        d0 = ndone; b0 = nbeg;
        startRun64(3);
        repeat (3) @(negedge clk);
        start = 1'b1; numOps = 5'd1;
        ldWe = 1'b1; ldAddr = 0; ldX = 64'h0000000000001234; ldOp = 3'b011;
        @(negedge clk);
        start = 1'b0; ldWe = 1'b0;
        waitDone64(80, "t4_done_wait");
        chk("t4_beg_pulses", 64'(nbeg - b0), 64'd3);
        chk("t4_done_pulses", 64'(ndone - d0), 64'd1);
        chk("t4_latmax", 64'(latMax), 64'd9);
        chk("t4_tmo_cleared", 64'(tmoErr), 64'd0);
        latArr[0] = 1;
        startRun64(1);
        waitDone64(20, "t4_rerun_wait");
        chk("t4_table_x", dX, 64'h4000000000000000);
        chk("t4_table_op", 64'(dAddSubt), 64'd1);
        chk("t4_rerun_latmax", 64'(latMax), 64'd1);

        // reset in WAIT aborts without done
        latArr[0] = 0;
        startRun64(1);
        repeat (6) @(negedge clk);
        d0 = ndone;
        rst = 1'b1;
        @(negedge clk);
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_x", dX, 64'd0);
        chk("t5_y", dY, 64'd0);
        chk("t5_addsubt", 64'(dAddSubt), 64'd0);
        chk("t5_beg", 64'(dBeg), 64'd0);
        chk("t5_dutrst", 64'(dRst), 64'd0);
        rst = 1'b0;
        repeat (25) @(negedge clk);
        chk("t5_no_done", 64'(ndone - d0), 64'd0);

        // num_ops = 0: done two cycles after start, no begin
        b0 = nbeg;
        @(negedge clk);
        start = 1'b1; numOps = 5'd0;
        @(negedge clk);
        start = 1'b0;
        chk("t5_zero_done_early", 64'(done), 64'd0);
        chk("t5_zero_busy_fin", 64'(busy), 64'd1);
        @(negedge clk);
        chk("t5_zero_done", 64'(done), 64'd1);
        chk("t5_zero_busy_after", 64'(busy), 64'd0);
        @(negedge clk);
        chk("t5_zero_done_len", 64'(done), 64'd0);
        chk("t5_zero_no_beg", 64'(nbeg - b0), 64'd0);

        // 32-bit instance: 1.0f + 1.0f, then with overflow flagged
        @(negedge clk);
        bLdWe = 1'b1; bLdAddr = 0; bLdX = 32'h3F800000; bLdY = 32'h3F800000; bLdOp = 3'b000;
        @(negedge clk);
        bLdWe = 1'b0;
        bResult = 32'h40000000; bOvf = 1'b0;
        run32("t6_done_wait");
        chk("t6_result", 64'(bRdResult), 64'h40000000);
        chk("t6_status", 64'(bRdStatus), 64'h003);
        bOvf = 1'b1;
        run32("t6_ovf_done_wait");
        chk("t6_ovf_status", 64'(bRdStatus), 64'h203);
        chk("t6_tmo_err", 64'(bTmoErr), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
